id_bypass_unit: RTL

Parametrised operand bypass and hazard unit for the decode stage. It replaces the fixed EX/MEM forwarding compares with an internal scoreboard of in-flight register writes, one entry per downstream stage. It supplies each decode read port with the youngest available value, or raises a stall request when that value is not yet produced (load-use and multi-cycle results). It sits between regfile read data and the decode operand outputs.

---
 rtl/id_bypass_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/id_bypass_unit.sv
// Decode-stage operand bypass: scoreboard of in-flight writes, youngest-match forwarding and stall request.
// Optional macro ID_BYPASS_STATS_EN adds a saturating stall-cycle counter (stall_cnt_o).
module id_bypass_unit #(
  parameter int NUM_RD = 2,
  parameter int DEPTH  = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hold_i,
  input  logic                     flush_i,
  input  logic                     id_issue_i,
  input  logic                     id_wreg_i,
  input  logic [ADDR_W-1:0]        id_wd_i,
  input  logic [DEPTH-1:0]         stg_rdy_i,
  input  logic [DEPTH*DATA_W-1:0]  stg_wdata_i,
  input  logic [NUM_RD-1:0]        rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  input  logic [NUM_RD*DATA_W-1:0] rd_regfile_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic                     stallreq_o
`ifdef ID_BYPASS_STATS_EN
  ,
  output logic [31:0]              stall_cnt_o
`endif
);

  logic              valid_q [DEPTH];
  logic              ready_q [DEPTH];
  logic [ADDR_W-1:0] wd_q    [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];

  logic              ready_eff [DEPTH];
  logic [DATA_W-1:0] data_eff  [DEPTH];
  logic [NUM_RD-1:0] port_stall;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ready_eff[k] = ready_q[k] | stg_rdy_i[k];
      data_eff[k]  = ready_q[k] ? data_q[k] : stg_wdata_i[k*DATA_W +: DATA_W];
    end
  end

  // Control state: valid/ready, the only fields under reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        ready_q[k] <= 1'b0;
      end
    end else if (flush_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        ready_q[k] <= 1'b0;
      end
    end else if (hold_i) begin
      for (int k = 0; k < DEPTH; k++)
        ready_q[k] <= ready_eff[k];
    end else begin
      valid_q[0] <= id_issue_i & id_wreg_i & (id_wd_i != '0);
      ready_q[0] <= 1'b0;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        ready_q[k] <= ready_eff[k-1];
      end
    end
  end

  // Payload: address and data follow the same shift/hold pattern, no reset needed
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      if (hold_i) begin
        for (int k = 0; k < DEPTH; k++)
          data_q[k] <= data_eff[k];
      end else begin
        wd_q[0]   <= id_wd_i;
        data_q[0] <= '0;
        for (int k = 1; k < DEPTH; k++) begin
          wd_q[k]   <= wd_q[k-1];
          data_q[k] <= data_eff[k-1];
        end
      end
    end
  end

  // Lookup: scan oldest to youngest so the youngest match overrides
  always_comb begin
    logic              hit;
    logic              rdy;
    logic [DATA_W-1:0] fwd;
    logic [ADDR_W-1:0] addr;
    rd_data_o  = rd_regfile_i;
    port_stall = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      hit  = 1'b0;
      rdy  = 1'b0;
      fwd  = rd_regfile_i[p*DATA_W +: DATA_W];
      addr = rd_addr_i[p*ADDR_W +: ADDR_W];
      for (int k = DEPTH-1; k >= 0; k--) begin
        if (rd_en_i[p] && (addr != '0) && valid_q[k] && (wd_q[k] == addr)) begin
          hit = 1'b1;
          rdy = ready_eff[k];
          fwd = data_eff[k];
        end
      end
      if (hit && rdy)
        rd_data_o[p*DATA_W +: DATA_W] = fwd;
      port_stall[p] = hit & ~rdy;
    end
  end

  assign stallreq_o = |port_stall;

`ifdef ID_BYPASS_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt_o <= '0;
    else if (stallreq_o && !hold_i && (stall_cnt_o != 32'hFFFF_FFFF))
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

endmodule
